// File: rtl/puzzle_step_sequencer.sv
// ---------------------------------------------------------------------------
// puzzle_step_sequencer
//
// Searches for the answer of the 2x3 sliding puzzle by repeatedly reading the
// current board, answer, step counter and last move out of the 16x28-bit
// puzzle register file, then either stopping with a status code or
// committing one blank-tile move.  This block is the only agent driving the
// register file's src0/src1/dst/we/data.
//
// Register map: r0 current board, r1 answer, r2 step counter,
//               r3 finding code, r4 last move ({valid, move[1:0]}).
// Board word:   cell p (p = row*3 + col) in bits [4p+3:4p]; bits [27:24] are
//               a tag that is never compared and is carried through writes.
// Moves (of the blank): U=0 (p-3), D=1 (p+3), L=2 (p-1), R=3 (p+1).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             pulse, accepted only while idle
//   abort             level, returns to idle from any busy state
//   rf_src0, rf_src1  register file read addresses (async read data returns
//                     on rf_outa / rf_outb in the same cycle)
//   rf_dst, rf_we,    register file write port (sampled by the file on the
//   rf_data           next rising edge)
//   busy              high in every state except IDLE
//   done              one-cycle pulse when a run completes normally
//   status            0 none, 1 solved, 2 step limit, 3 no blank; held
//                     until the next accepted start
//   trace_valid, trace_move, trace_blank
//                     present only when MOVE_TRACE_EN is defined; pulse in
//                     each board-commit cycle with the move and the
//                     pre-move blank index
//
// Optional feature macro: MOVE_TRACE_EN (undefined by default).
//
// Handshake: start is a single-cycle request with no ready; it is acted on
// only when the FSM is idle and is silently dropped otherwise.  The register
// file write port has no back-pressure: a write happens on every rising edge
// where rf_we is high.
// ---------------------------------------------------------------------------
module puzzle_step_sequencer #(
  parameter logic [27:0] MAX_STEPS = 28'd1024,
  parameter logic [3:0]  BLANK     = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  rf_src0,
  output logic [3:0]  rf_src1,
  output logic [3:0]  rf_dst,
  output logic        rf_we,
  output logic [27:0] rf_data,
  input  logic [27:0] rf_outa,
  input  logic [27:0] rf_outb,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status
`ifdef MOVE_TRACE_EN
  ,
  output logic        trace_valid,
  output logic [1:0]  trace_move,
  output logic [2:0]  trace_blank
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_RD_A, S_RD_B, S_CHECK,
    S_WR_CUR, S_WR_NEXT, S_WR_CNT, S_WR_FIND, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [27:0]  cur_q, cur_d;
  logic [27:0]  ans_q, ans_d;
  logic [27:0]  cnt_q, cnt_d;
  logic [2:0]   last_q, last_d;
  logic [1:0]   code_q, code_d;
  logic [1:0]   move_q, move_d;
  logic [2:0]   blank_q, blank_d;
  logic [23:0]  swap_q, swap_d;
  logic [1:0]   status_q, status_d;

  // Tag bits of the answer word are never compared.
  logic         unused_ans_tag;
  assign unused_ans_tag = ^ans_q[27:24];

  // ---------------------------------------------------------------------
  // Step decision logic (evaluated from the latched board / last move)
  // ---------------------------------------------------------------------
  logic        has_blank;
  logic [2:0]  blank_idx;
  logic [1:0]  scan_start;
  logic [1:0]  inv_last;
  logic [1:0]  cand;
  logic [1:0]  sel_move;
  logic        found;
  logic [2:0]  tgt_idx;
  logic [23:0] swapped;
  logic [27:0] cnt_inc;

  function automatic logic move_legal(input logic [2:0] p, input logic [1:0] m);
    logic       row1;
    logic [2:0] col;
    row1 = (p >= 3'd3);
    col  = row1 ? (p - 3'd3) : p;
    case (m)
      2'd0:    move_legal = row1;
      2'd1:    move_legal = !row1;
      2'd2:    move_legal = (col != 3'd0);
      default: move_legal = (col != 3'd2);
    endcase
  endfunction

  always_comb begin
    // Scan from the top so the lowest matching cell is the one kept.
    has_blank = 1'b0;
    blank_idx = 3'd0;
    for (int p = 5; p >= 0; p--) begin
      if (cur_q[4*p +: 4] == BLANK) begin
        has_blank = 1'b1;
        blank_idx = 3'(p);
      end
    end

    // Rotate the candidate order after a valid last move so the search does
    // not keep retrying the same direction; the inverse of a valid last
    // move is never taken (U^1=D, L^1=R).
    scan_start = last_q[2] ? (last_q[1:0] + 2'd1) : 2'd0;
    inv_last   = last_q[1:0] ^ 2'b01;
    found      = 1'b0;
    sel_move   = 2'd0;
    cand       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = scan_start + 2'(i);
      if (!found && move_legal(blank_idx, cand) && !(last_q[2] && (cand == inv_last))) begin
        found    = 1'b1;
        sel_move = cand;
      end
    end

    case (sel_move)
      2'd0:    tgt_idx = blank_idx - 3'd3;
      2'd1:    tgt_idx = blank_idx + 3'd3;
      2'd2:    tgt_idx = blank_idx - 3'd1;
      default: tgt_idx = blank_idx + 3'd1;
    endcase

    swapped = cur_q[23:0];
    swapped[{tgt_idx, 2'b00} +: 4]   = cur_q[{blank_idx, 2'b00} +: 4];
    swapped[{blank_idx, 2'b00} +: 4] = cur_q[{tgt_idx, 2'b00} +: 4];

    cnt_inc = (cnt_q == 28'hFFF_FFFF) ? cnt_q : (cnt_q + 28'd1);
  end

  // ---------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    ans_d    = ans_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    code_d   = code_q;
    move_d   = move_q;
    blank_d  = blank_q;
    swap_d   = swap_q;
    status_d = status_q;
    rf_src0  = 4'd0;
    rf_src1  = 4'd1;
    rf_dst   = 4'd0;
    rf_we    = 1'b0;
    rf_data  = 28'd0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CLR;
          status_d = 2'd0;
        end
      end
      S_CLR: begin
        rf_we   = 1'b1;
        rf_dst  = 4'd3;
        state_d = S_RD_A;
      end
      S_RD_A: begin
        cur_d   = rf_outa;
        ans_d   = rf_outb;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        rf_src0 = 4'd2;
        rf_src1 = 4'd4;
        cnt_d   = rf_outa;
        last_d  = rf_outb[2:0];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cur_q[23:0] == ans_q[23:0]) begin
          code_d  = 2'd1;
          state_d = S_WR_FIND;
        end else if (cnt_q >= MAX_STEPS) begin
          code_d  = 2'd2;
          state_d = S_WR_FIND;
        end else if (!has_blank) begin
          code_d  = 2'd3;
          state_d = S_WR_FIND;
        end else begin
          move_d  = sel_move;
          blank_d = blank_idx;
          swap_d  = swapped;
          state_d = S_WR_CUR;
        end
      end
      S_WR_CUR: begin
        rf_we   = 1'b1;
        rf_dst  = 4'd0;
        rf_data = {cur_q[27:24], swap_q};
        state_d = S_WR_NEXT;
      end
      S_WR_NEXT: begin
        rf_we   = 1'b1;
        rf_dst  = 4'd4;
        rf_data = {25'd0, 1'b1, move_q};
        state_d = S_WR_CNT;
      end
      S_WR_CNT: begin
        rf_we   = 1'b1;
        rf_dst  = 4'd2;
        rf_data = cnt_inc;
        state_d = S_RD_A;
      end
      S_WR_FIND: begin
        rf_we    = 1'b1;
        rf_dst   = 4'd3;
        rf_data  = {26'd0, code_q};
        status_d = code_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition; the current cycle's write (driven
    // above) still lands, but status keeps its old value.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      status_d = status_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cur_q    <= 28'd0;
      ans_q    <= 28'd0;
      cnt_q    <= 28'd0;
      last_q   <= 3'd0;
      code_q   <= 2'd0;
      move_q   <= 2'd0;
      blank_q  <= 3'd0;
      swap_q   <= 24'd0;
      status_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      ans_q    <= ans_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      code_q   <= code_d;
      move_q   <= move_d;
      blank_q  <= blank_d;
      swap_q   <= swap_d;
      status_q <= status_d;
    end
  end

  assign status = status_q;

`ifdef MOVE_TRACE_EN
  assign trace_valid = (state_q == S_WR_CUR);
  assign trace_move  = trace_valid ? move_q  : 2'd0;
  assign trace_blank = trace_valid ? blank_q : 3'd0;
`else
  // blank_q only feeds the trace outputs.
  logic unused_blank;
  assign unused_blank = ^blank_q;
`endif

endmodule

// File: tb/tb_puzzle_step_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for puzzle_step_sequencer.  Hosts a behavioural 16x28 register
// file (async reads, sync write, plus a bench-side preload port), a
// scoreboard of expected register-file writes, a reference search model,
// a table of run vectors and hand-written abort / busy-start / reset runs.
// The DUT is built with MAX_STEPS = 3 so the step limit is reachable.
// ---------------------------------------------------------------------------
module tb_puzzle_step_sequencer;

  localparam logic [27:0] MAX = 28'd3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        start, abort;
  logic [3:0]  rf_src0, rf_src1, rf_dst;
  logic        rf_we;
  logic [27:0] rf_data, rf_outa, rf_outb;
  logic        busy, done;
  logic [1:0]  status;
`ifdef MOVE_TRACE_EN
  logic        trace_valid;
  logic [1:0]  trace_move;
  logic [2:0]  trace_blank;
`endif

  puzzle_step_sequencer #(.MAX_STEPS(MAX), .BLANK(4'h0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .rf_src0 (rf_src0),
    .rf_src1 (rf_src1),
    .rf_dst  (rf_dst),
    .rf_we   (rf_we),
    .rf_data (rf_data),
    .rf_outa (rf_outa),
    .rf_outb (rf_outb),
    .busy    (busy),
    .done    (done),
    .status  (status)
`ifdef MOVE_TRACE_EN
    ,
    .trace_valid (trace_valid),
    .trace_move  (trace_move),
    .trace_blank (trace_blank)
`endif
  );

  // ---------------- register file model ----------------
  logic [27:0] rf_mem [16];
  logic        tb_we;
  logic [3:0]  tb_addr;
  logic [27:0] tb_wdata;

  always @(posedge clk) begin
    if (tb_we) rf_mem[tb_addr] <= tb_wdata;
    else if (rf_we) rf_mem[rf_dst] <= rf_data;
  end
  assign rf_outa = rf_mem[rf_src0];
  assign rf_outb = rf_mem[rf_src1];

  // ---------------- scoreboard ----------------
  int          checks;
  int          errors;
  int          done_cnt;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write: got unexpected write dst=%0d data=%h", rf_dst, rf_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({rf_dst, rf_data} !== exp_w) begin
          errors++;
          $display("FAIL rf_write: got dst=%0d data=%h expected dst=%0d data=%h",
                   rf_dst, rf_data, exp_w[31:28], exp_w[27:0]);
        end
      end
    end
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Target cell of moving the blank at p in direction m, or -1 if illegal.
  function automatic int tgt(input int p, input int m);
    int r, c;
    r = p / 3;
    c = p % 3;
    case (m)
      0:       tgt = (r == 1) ? p - 3 : -1;
      1:       tgt = (r == 0) ? p + 3 : -1;
      2:       tgt = (c > 0)  ? p - 1 : -1;
      default: tgt = (c < 2)  ? p + 1 : -1;
    endcase
  endfunction

  function automatic int opposite(input int m);
    case (m)
      0:       opposite = 1;
      1:       opposite = 0;
      2:       opposite = 3;
      default: opposite = 2;
    endcase
  endfunction

  // Pushes the full expected write sequence of one run onto exp_q.
  task automatic model_run(input logic [27:0] b_in, input logic [27:0] ans,
                           input logic [27:0] cnt_in, input logic [27:0] last_in);
    logic [27:0] b, c, l;
    logic [3:0]  tmp;
    logic [1:0]  code;
    int          bl, first, mv, cnd, t;
    b = b_in; c = cnt_in; l = last_in; code = 2'd0;
    exp_q.push_back({4'd3, 28'd0});
    for (int it = 0; it < 64 && code == 2'd0; it++) begin
      bl = -1;
      for (int p = 0; p < 6; p++) if (bl < 0 && b[4*p +: 4] == 4'h0) bl = p;
      if (b[23:0] == ans[23:0]) code = 2'd1;
      else if (c >= MAX) code = 2'd2;
      else if (bl < 0) code = 2'd3;
      else begin
        first = l[2] ? (int'(l[1:0]) + 1) % 4 : 0;
        mv = -1;
        for (int k = 0; k < 4; k++) begin
          cnd = (first + k) % 4;
          if (mv < 0 && tgt(bl, cnd) >= 0 && !(l[2] && cnd == opposite(int'(l[1:0])))) mv = cnd;
        end
        t = tgt(bl, mv);
        tmp = b[4*t +: 4];
        b[4*t +: 4] = b[4*bl +: 4];
        b[4*bl +: 4] = tmp;
        exp_q.push_back({4'd0, b});
        l = {25'd0, 1'b1, 2'(mv)};
        exp_q.push_back({4'd4, l});
        c = (c == 28'hFFF_FFFF) ? c : c + 28'd1;
        exp_q.push_back({4'd2, c});
      end
    end
    exp_q.push_back({4'd3, 26'd0, code});
  endtask

  // ---------------- driver tasks ----------------
  task automatic rf_write(input logic [3:0] a, input logic [27:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic preload(input logic [27:0] r0, input logic [27:0] r1,
                         input logic [27:0] r2, input logic [27:0] r4);
    rf_write(4'd0, r0);
    rf_write(4'd1, r1);
    rf_write(4'd2, r2);
    rf_write(4'd3, 28'h0AB_CDEF);
    rf_write(4'd4, r4);
  endtask

  // Pulses start for one cycle; returns on the negedge after it was sampled.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Latency = index of the rising edge (counted from the edge that sampled
  // start) that closes the cycle in which done is high; 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k + 1;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [27:0] r0, r1, r2, r4;
    logic [1:0]  code;
    logic [27:0] f0, f2, f4;
    int          steps;
  } vec_t;

  vec_t vecs[9];
  int   lat, d0;

  initial begin
    checks = 0; errors = 0; done_cnt = 0;
    start = 1'b0; abort = 1'b0; tb_we = 1'b0; tb_addr = 4'd0; tb_wdata = 28'd0;
    rst_n = 1'b0;

    //            r0            r1            r2     r4     code  f0            f2     f4     steps
    vecs[0] = '{28'hF054321, 28'hF054321, 28'd0, 28'd0, 2'd1, 28'hF054321, 28'd0, 28'd0, 0};
    vecs[1] = '{28'hF354021, 28'hF054321, 28'd0, 28'd0, 2'd1, 28'hF054321, 28'd1, 28'd5, 1};
    vecs[2] = '{28'hF123450, 28'hF054321, 28'd0, 28'd0, 2'd2, 28'hF152403, 28'd3, 28'd4, 3};
    vecs[3] = '{28'hF654321, 28'hF054321, 28'd0, 28'd0, 2'd3, 28'hF654321, 28'd0, 28'd0, 0};
    vecs[4] = '{28'hA054321, 28'h3054321, 28'd0, 28'd0, 2'd1, 28'hA054321, 28'd0, 28'd0, 0};
    vecs[5] = '{28'hF123450, 28'hF054321, 28'd5, 28'd0, 2'd2, 28'hF123450, 28'd5, 28'd0, 0};
    vecs[6] = '{28'hF354021, 28'hF054321, 28'd0, 28'd5, 2'd2, 28'hF340251, 28'd3, 28'd6, 3};
    vecs[7] = '{28'hF000321, 28'hF054321, 28'd2, 28'd0, 2'd2, 28'hF001320, 28'd3, 28'd4, 1};
    vecs[8] = '{28'hF354021, 28'hF054321, 28'd0, 28'd3, 2'd1, 28'hF054321, 28'd1, 28'd5, 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_src0",   32'(rf_src0), 32'd0);
    check("rst_src1",   32'(rf_src1), 32'd1);
    check("rst_dst",    32'(rf_dst),  32'd0);
    check("rst_data",   32'(rf_data), 32'd0);
    check("rst_we",     32'(rf_we),   32'd0);
    check("rst_busy",   32'(busy),    32'd0);
    check("rst_done",   32'(done),    32'd0);
    check("rst_status", 32'(status),  32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) rf_write(4'(a), 28'd0);

    // Table-driven runs
    for (int i = 0; i < 9; i++) begin
      preload(vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].r4);
      model_run(vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].r4);
      d0 = done_cnt;
      pulse_start();
      check($sformatf("v%0d_status_clr", i), 32'(status), 32'd0);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(6 + 6 * vecs[i].steps));
      check($sformatf("v%0d_status", i), 32'(status), 32'(vecs[i].code));
      @(negedge clk);
      check($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_sb_empty", i), 32'(exp_q.size()), 32'd0);
      check($sformatf("v%0d_r0", i), 32'(rf_mem[0]), 32'(vecs[i].f0));
      check($sformatf("v%0d_r2", i), 32'(rf_mem[2]), 32'(vecs[i].f2));
      check($sformatf("v%0d_r3", i), 32'(rf_mem[3]), 32'(vecs[i].code));
      check($sformatf("v%0d_r4", i), 32'(rf_mem[4]), 32'(vecs[i].f4));
      check($sformatf("v%0d_done_cnt", i), 32'(done_cnt - d0), 32'd1);
    end

    // Abort in WR_NEXT of step 1: r4 lands, r2 untouched, no done.
    preload(28'hF354021, 28'hF000001, 28'd0, 28'd0);
    exp_q.push_back({4'd3, 28'd0});
    exp_q.push_back({4'd0, 28'hF054321});
    exp_q.push_back({4'd4, 28'd5});
    d0 = done_cnt;
    pulse_start();
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rf_we && rf_dst == 4'd4) begin
        lat = 1;
        break;
      end
    end
    check("abort_reach_wr_next", 32'(lat), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(rf_we), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_r2", 32'(rf_mem[2]), 32'd0);
    check("abort_r4", 32'(rf_mem[4]), 32'd5);
    check("abort_r0", 32'(rf_mem[0]), 32'hF054321);
    check("abort_status", 32'(status), 32'd0);
    check("abort_sb_empty", 32'(exp_q.size()), 32'd0);

    // start while busy is ignored
    preload(28'hF123450, 28'hF054321, 28'd0, 28'd0);
    model_run(28'hF123450, 28'hF054321, 28'd0, 28'd0);
    d0 = done_cnt;
    pulse_start();
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_status", 32'(status), 32'd0);
    wait_done(lat);
    repeat (4) @(negedge clk);
    check("busy_start_idle", 32'(busy), 32'd0);
    check("busy_start_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("busy_start_sb_empty", 32'(exp_q.size()), 32'd0);
    check("busy_start_r0", 32'(rf_mem[0]), 32'hF152403);
    check("busy_start_status_end", 32'(status), 32'd2);

    // Reset in the middle of a step: immediate idle, no further writes.
    preload(28'hF123450, 28'hF054321, 28'd0, 28'd0);
    model_run(28'hF123450, 28'hF054321, 28'd0, 28'd0);
    d0 = done_cnt;
    pulse_start();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_we", 32'(rf_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_status", 32'(status), 32'd0);
    check("mid_rst_src1", 32'(rf_src1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
